// File: rtl/uc4b_pkg.sv
// Shared widths for the uc4b free-running counter.
package uc4b_pkg;

   localparam int unsigned UC4B_WIDTH = 5;

   // All-ones terminal count for a given width, safe at the 32-bit limit.
   function automatic int unsigned uc4b_full_scale(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/uc4b.sv
// Free-running up counter, wraps to 0 after MAX_VAL; async active-high reset.
module uc4b
   import uc4b_pkg::*;
#(
   parameter int unsigned WIDTH   = UC4B_WIDTH,
   parameter int unsigned MAX_VAL = uc4b_full_scale(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign cnt_d = (cnt_q == TERM) ? '0 : cnt_q + WIDTH'(1);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

   if (WIDTH < 1) begin : g_bad_width
      $error("uc4b: WIDTH must be at least 1");
   end
   if (MAX_VAL < 1 || MAX_VAL > uc4b_full_scale(WIDTH)) begin : g_bad_max
      $error("uc4b: MAX_VAL must lie in 1 .. 2**WIDTH-1");
   end

endmodule

// File: tb/tb_uc4b.sv
// Directed bench for uc4b: default wrap at 31 and a MAX_VAL=9 instance.
module tb_uc4b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] cnt;
   logic [4:0] cnt_m9;

   int checks = 0;
   int errors = 0;

   uc4b dut (
      .clk (clk),
      .rst (rst),
      .cnt (cnt)
   );

   uc4b #(.WIDTH(5), .MAX_VAL(9)) dut_m9 (
      .clk (clk),
      .rst (rst),
      .cnt (cnt_m9)
   );

   always #10 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   // rst high from 0 to 100 ns; edges at 10..90 must all show 0.
   task automatic test_reset();
      #1;
      checks++;
      if (cnt !== 5'd0) begin
         errors++;
         $display("FAIL reset_t0: cnt=%0d required 0", cnt);
      end
      for (int i = 0; i < 5; i++) begin
         edge_sample();
         checks++;
         if (cnt !== 5'd0 || cnt_m9 !== 5'd0) begin
            errors++;
            $display("FAIL reset_edge%0d: cnt=%0d cnt_m9=%0d required 0", i, cnt, cnt_m9);
         end
      end
      #9;
      rst = 1'b0;
   endtask

   // Edge k after release must give k mod 32: 1 at 110 ns, 20 at 490 ns, 30,31,0,1 at 30..33.
   task automatic test_count_and_wrap();
      logic [4:0] exp;
      for (int k = 1; k <= 33; k++) begin
         edge_sample();
         exp = 5'(k % 32);
         checks++;
         if (cnt !== exp) begin
            errors++;
            $display("FAIL count_edge%0d: cnt=%0d required %0d (t=%0t)", k, cnt, exp, $time);
         end
      end
   endtask

   // Count to 12, then a 3 ns reset pulse between edges.
   task automatic test_async_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) edge_sample();
      checks++;
      if (cnt !== 5'd12) begin
         errors++;
         $display("FAIL async_pre: cnt=%0d required 12", cnt);
      end
      #4;
      rst = 1'b1;
      #1;
      checks++;
      if (cnt !== 5'd0) begin
         errors++;
         $display("FAIL async_clear: cnt=%0d required 0 without clock edge", cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (cnt !== 5'd0) begin
         errors++;
         $display("FAIL async_hold: cnt=%0d required 0 after release before edge", cnt);
      end
      edge_sample();
      checks++;
      if (cnt !== 5'd1) begin
         errors++;
         $display("FAIL async_resume: cnt=%0d required 1", cnt);
      end
   endtask

   // rst held across 5 edges mid-count, then restart at 1.
   task automatic test_reset_held();
      for (int k = 0; k < 6; k++) edge_sample();
      #4;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         edge_sample();
         checks++;
         if (cnt !== 5'd0 || cnt_m9 !== 5'd0) begin
            errors++;
            $display("FAIL held_edge%0d: cnt=%0d cnt_m9=%0d required 0", i, cnt, cnt_m9);
         end
      end
      #4;
      rst = 1'b0;
      edge_sample();
      checks++;
      if (cnt !== 5'd1) begin
         errors++;
         $display("FAIL held_restart: cnt=%0d required 1", cnt);
      end
   endtask

   // MAX_VAL=9 instance: edge k after release gives k mod 10, never above 9.
   task automatic test_mod10();
      logic [4:0] exp;
      rst = 1'b1;
      #3;
      rst = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         edge_sample();
         exp = 5'(k % 10);
         checks++;
         if (cnt_m9 !== exp || cnt_m9 > 5'd9) begin
            errors++;
            $display("FAIL mod10_edge%0d: cnt_m9=%0d required %0d", k, cnt_m9, exp);
         end
      end
      checks++;
      if (cnt !== 5'd25) begin
         errors++;
         $display("FAIL mod10_default_peer: cnt=%0d required 25", cnt);
      end
   endtask

   initial begin
      test_reset();
      test_count_and_wrap();
      test_async_reset();
      test_reset_held();
      test_mod10();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
